// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchroniser + 4-state qualification FSM, active-low level out.
// Optional glitch counter port/register enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Btt_raw,
  output logic       Btt_out,
  output logic       Btt_stable
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    STABLE_HI = 2'd0,
    CHECK_LO  = 2'd1,
    STABLE_LO = 2'd2,
    CHECK_HI  = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 stable_q, stable_d;
  logic                 at_max;

  assign at_max = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= STABLE_HI;
      cnt_q    <= '0;
      out_q    <= 1'b1;
      stable_q <= 1'b1;
    end else begin
      sync1_q  <= Btt_raw;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      stable_q <= stable_d;
    end
  end

  // A revert of sync2 in a CHECK state always wins, even on the final qualifying edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE_HI: if (!sync2_q) state_d = CHECK_LO;
      CHECK_LO:  if (sync2_q)  state_d = STABLE_HI;
                 else if (at_max) state_d = STABLE_LO;
      STABLE_LO: if (sync2_q)  state_d = CHECK_HI;
      CHECK_HI:  if (!sync2_q) state_d = STABLE_LO;
                 else if (at_max) state_d = STABLE_HI;
      default:   state_d = STABLE_HI;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    stable_d = (state_d == STABLE_HI) || (state_d == STABLE_LO);
    case (state_q)
      STABLE_HI: if (!sync2_q) cnt_d = '0;
      CHECK_LO:  if (!sync2_q) begin
                   if (at_max) out_d = 1'b0;
                   else        cnt_d = cnt_q + CNT_WIDTH'(1);
                 end
      STABLE_LO: if (sync2_q) cnt_d = '0;
      CHECK_HI:  if (sync2_q) begin
                   if (at_max) out_d = 1'b1;
                   else        cnt_d = cnt_q + CNT_WIDTH'(1);
                 end
      default:   begin
                   cnt_d = '0;
                   out_d = 1'b1;
                 end
    endcase
  end

  assign Btt_out    = out_q;
  assign Btt_stable = stable_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic       glitch_ev;

  assign glitch_ev = ((state_q == CHECK_LO) && sync2_q) ||
                     ((state_q == CHECK_HI) && !sync2_q);

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_ev && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) glitch_q <= '0;
    else       glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule
